// File: rtl/pong_pkg.sv
// Shared definitions for the pong video path: raster timing defaults, colour
// encodings, score block geometry and the game state encoding.
package pong_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int PIX_DIV_D  = 2;
  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  // Pixel byte layout: RRRGGGBB
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam logic [7:0] COLOR_BALL   = 8'hFF;
  localparam logic [7:0] COLOR_PADDLE = 8'h1C;
  localparam logic [7:0] COLOR_SCORE  = 8'hE0;
  localparam logic [7:0] COLOR_BORDER = 8'h92;
  localparam logic [7:0] COLOR_OVER   = 8'h40;
  localparam logic [7:0] COLOR_BLACK  = 8'h00;

  localparam int SCORE_Y0    = 2;
  localparam int SCORE_Y1    = 9;
  localparam int SCORE_W     = 8;
  localparam int SCORE_PITCH = 12;
  localparam int SCORE_L_X0  = 16;
  localparam int SCORE_R_X0  = 616;
  localparam int SCORE_MAX   = 16;

  typedef enum logic [1:0] {
    GS_IDLE   = 2'd0,
    GS_PLAY   = 2'd1,
    GS_SCORED = 2'd2,
    GS_OVER   = 2'd3
  } game_state_e;

  // Half-open span test [lo, lo+len); 11 bits keeps lo+len from wrapping.
  function automatic logic span_hit(input logic [10:0] p, input logic [10:0] lo,
                                    input logic [10:0] len);
    return (p >= lo) && (p < (lo + len));
  endfunction

endpackage

// File: rtl/pong_vga_renderer_timing.sv
// Raster timing: pixel divider, h/v counters, sync windows, active-region flag
// and the start-of-vertical-blanking strobe.
module vga_timing
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int PIX_DIV  = PIX_DIV_D
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_pix_en,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_active,
  output logic       o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;

  assign o_pix_en = (r_div == DIV_W'(PIX_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= o_pix_en ? '0 : r_div + DIV_W'(1);
      if (o_pix_en) begin
        if (r_h == 10'(H_TOTAL - 1)) begin
          r_h <= '0;
          r_v <= (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_hsync_n     = !((r_h >= 10'(H_ACTIVE + H_FP)) &&
                           (r_h <= 10'(H_ACTIVE + H_FP + H_SYNC - 1)));
  assign o_vsync_n     = !((r_v >= 10'(V_ACTIVE + V_FP)) &&
                           (r_v <= 10'(V_ACTIVE + V_FP + V_SYNC - 1)));
  assign o_active      = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
  assign o_frame_start = o_pix_en && (r_h == 10'd0) && (r_v == 10'(V_ACTIVE));

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong display back end: snapshots game state once per frame at the start of
// vertical blanking and composites ball, paddles, score and border per pixel.
module pong_vga_renderer
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int PIX_DIV  = PIX_DIV_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ball_pos_x,
  input  logic [9:0] ball_pos_y,
  input  logic [9:0] player_left_pos,
  input  logic [9:0] player_right_pos,
  input  logic [9:0] paddle_width,
  input  logic [9:0] paddle_height,
  input  logic [9:0] paddle_offset,
  input  logic [9:0] ball_size,
  input  logic [9:0] border_top,
  input  logic [9:0] border_bottom,
  input  logic [9:0] border_left,
  input  logic [9:0] border_right,
  input  logic [3:0] score_left,
  input  logic [3:0] score_right,
  input  logic       game_over_signal,
  output logic       frame_clk,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
);

  logic       w_pix_en, w_hsync_n, w_vsync_n, w_active, w_frame_start;
  logic [9:0] w_h, w_v;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV)
  ) u_timing (
    .clk(clk), .reset(reset), .o_pix_en(w_pix_en), .o_h(w_h), .o_v(w_v),
    .o_hsync_n(w_hsync_n), .o_vsync_n(w_vsync_n), .o_active(w_active),
    .o_frame_start(w_frame_start)
  );

  logic [10:0] r_bx, r_by, r_lp, r_rp, r_pw, r_ph, r_po, r_bs;
  logic [10:0] r_bt, r_bb, r_bl, r_br;
  logic [3:0]  r_score_l, r_score_r;
  logic        r_over;

  always_ff @(posedge clk) begin
    if (reset) begin
      {r_bx, r_by, r_lp, r_rp, r_pw, r_ph, r_po, r_bs} <= '0;
      {r_bt, r_bb, r_bl, r_br}                         <= '0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_over    <= 1'b0;
    end else if (w_frame_start) begin
      r_bx      <= {1'b0, ball_pos_x};
      r_by      <= {1'b0, ball_pos_y};
      r_lp      <= {1'b0, player_left_pos};
      r_rp      <= {1'b0, player_right_pos};
      r_pw      <= {1'b0, paddle_width};
      r_ph      <= {1'b0, paddle_height};
      r_po      <= {1'b0, paddle_offset};
      r_bs      <= {1'b0, ball_size};
      r_bt      <= {1'b0, border_top};
      r_bb      <= {1'b0, border_bottom};
      r_bl      <= {1'b0, border_left};
      r_br      <= {1'b0, border_right};
      r_score_l <= score_left;
      r_score_r <= score_right;
      r_over    <= game_over_signal;
    end
  end

  logic [10:0] w_x11, w_y11;
  logic        w_ball, w_paddle, w_score, w_border, w_score_row;
  logic [SCORE_MAX-1:0] w_score_l, w_score_r;
  logic [7:0]  w_rgb_next;

  assign w_x11 = {1'b0, w_h};
  assign w_y11 = {1'b0, w_v};

  assign w_ball   = span_hit(w_x11, r_bx, r_bs) && span_hit(w_y11, r_by, r_bs);
  assign w_paddle = (span_hit(w_x11, r_bl + r_po, r_pw) && span_hit(w_y11, r_lp, r_ph)) ||
                    (span_hit(w_x11, r_br - r_po - r_pw, r_pw) && span_hit(w_y11, r_rp, r_ph));
  assign w_border = ((w_y11 == r_bt) || (w_y11 == r_bb)) && (w_x11 >= r_bl) && (w_x11 <= r_br);

  assign w_score_row = (w_y11 >= 11'(SCORE_Y0)) && (w_y11 <= 11'(SCORE_Y1));

  genvar gi;
  generate
    for (gi = 0; gi < SCORE_MAX; gi++) begin : g_score
      assign w_score_l[gi] = (r_score_l > 4'(gi)) &&
          span_hit(w_x11, 11'(SCORE_L_X0 + SCORE_PITCH * gi), 11'(SCORE_W));
      assign w_score_r[gi] = (r_score_r > 4'(gi)) &&
          span_hit(w_x11, 11'(SCORE_R_X0 - SCORE_PITCH * gi), 11'(SCORE_W));
    end
  endgenerate

  assign w_score = w_score_row && (|w_score_l || |w_score_r);

  always_comb begin
    w_rgb_next = r_over ? COLOR_OVER : COLOR_BLACK;
    if      (!w_active) w_rgb_next = COLOR_BLACK;
    else if (w_ball)    w_rgb_next = COLOR_BALL;
    else if (w_paddle)  w_rgb_next = COLOR_PADDLE;
    else if (w_score)   w_rgb_next = COLOR_SCORE;
    else if (w_border)  w_rgb_next = COLOR_BORDER;
  end

  logic       r_hsync, r_vsync, r_video_on;
  logic [7:0] r_rgb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
      r_rgb      <= '0;
    end else if (w_pix_en) begin
      r_hsync    <= w_hsync_n;
      r_vsync    <= w_vsync_n;
      r_video_on <= w_active;
      r_rgb      <= w_rgb_next;
    end
  end

  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign video_on  = r_video_on;
  assign rgb       = r_rgb;
  assign frame_clk = w_frame_start;
  assign pixel_x   = w_h;
  assign pixel_y   = w_v;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed bench for pong_vga_renderer on a shrunken raster so several whole
// frames fit in a short run; expected values derive from the bench's own timing.
module tb_pong_vga_renderer;

  localparam int H_ACT = 112, H_FP = 4, H_SYN = 8, H_BP = 4;
  localparam int V_ACT = 32,  V_FP = 2, V_SYN = 2, V_BP = 2;
  localparam int PDIV  = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int LINE_CLKS  = H_TOT * PDIV;
  localparam int FRAME_CLKS = V_TOT * LINE_CLKS;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] ball_pos_x, ball_pos_y, player_left_pos, player_right_pos;
  logic [9:0] paddle_width, paddle_height, paddle_offset, ball_size;
  logic [9:0] border_top, border_bottom, border_left, border_right;
  logic [3:0] score_left, score_right;
  logic       game_over_signal;
  logic       frame_clk, hsync, vsync, video_on;
  logic [7:0] rgb;
  logic [9:0] pixel_x, pixel_y;

  int total = 0;
  int bad   = 0;

  pong_vga_renderer #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP), .PIX_DIV(PDIV)
  ) dut (
    .clk(clk), .reset(reset),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .player_left_pos(player_left_pos), .player_right_pos(player_right_pos),
    .paddle_width(paddle_width), .paddle_height(paddle_height),
    .paddle_offset(paddle_offset), .ball_size(ball_size),
    .border_top(border_top), .border_bottom(border_bottom),
    .border_left(border_left), .border_right(border_right),
    .score_left(score_left), .score_right(score_right),
    .game_over_signal(game_over_signal),
    .frame_clk(frame_clk), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y)
  );

  always #5 clk = ~clk;

  // Waits for the raster to reach (x,y), then for the counter to move on; the
  // registered rgb at that point belongs to (x,y).
  task automatic sample_pixel(input int x, input int y, output logic [7:0] val,
                              output logic ok);
    ok  = 1'b0;
    val = 8'hxx;
    for (int n = 0; n < 2 * FRAME_CLKS; n++) begin
      @(negedge clk);
      if (pixel_x == 10'(x) && pixel_y == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int n = 0; n < PDIV + 2; n++) begin
        @(negedge clk);
        if (pixel_x != 10'(x)) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (ok) val = rgb;
  endtask

  task automatic wait_line(input int y, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 2 * FRAME_CLKS; n++) begin
      @(negedge clk);
      if (pixel_y == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    ball_pos_x = 10'd100;  ball_pos_y = 10'd20;  ball_size = 10'd8;
    player_left_pos = 10'd20;  player_right_pos = 10'd31;
    paddle_width = 10'd4;  paddle_height = 10'd10;  paddle_offset = 10'd10;
    border_top = 10'd1;  border_bottom = 10'd30;
    border_left = 10'd4;  border_right = 10'd104;
    score_left = 4'd0;  score_right = 4'd0;  game_over_signal = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 8'h00 || video_on !== 1'b0 ||
        frame_clk !== 1'b0 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
      bad++;
      $display("FAIL reset_state: hs=%b vs=%b rgb=%h von=%b fclk=%b x=%0d y=%0d, required 1 1 00 0 0 0 0",
               hsync, vsync, rgb, video_on, frame_clk, pixel_x, pixel_y);
    end
    reset = 1'b0;
  endtask

  task automatic test_timing;
    int cyc, h_fall, h_per_n, h_per_bad, h_low_n, h_low_bad;
    int v_fall, v_per_n, v_per_bad, v_low_n, v_low_bad;
    int pulses, wide_bad, coin_bad, max_x;
    logic prev_h, prev_v, prev_f;
    h_fall = -1; v_fall = -1;
    h_per_n = 0; h_per_bad = 0; h_low_n = 0; h_low_bad = 0;
    v_per_n = 0; v_per_bad = 0; v_low_n = 0; v_low_bad = 0;
    pulses = 0; wide_bad = 0; coin_bad = 0; max_x = 0;
    prev_h = hsync; prev_v = vsync; prev_f = frame_clk;
    for (cyc = 1; cyc <= 3 * FRAME_CLKS; cyc++) begin
      @(negedge clk);
      if (prev_h && !hsync) begin
        if (h_fall >= 0) begin
          h_per_n++;
          if (cyc - h_fall != LINE_CLKS) h_per_bad++;
        end
        h_fall = cyc;
      end
      if (!prev_h && hsync && h_fall >= 0) begin
        h_low_n++;
        if (cyc - h_fall != H_SYN * PDIV) h_low_bad++;
      end
      if (prev_v && !vsync) begin
        if (v_fall >= 0) begin
          v_per_n++;
          if (cyc - v_fall != FRAME_CLKS) v_per_bad++;
        end
        v_fall = cyc;
      end
      if (!prev_v && vsync && v_fall >= 0) begin
        v_low_n++;
        if (cyc - v_fall != V_SYN * LINE_CLKS) v_low_bad++;
      end
      if (frame_clk) begin
        if (!prev_f) pulses++;
        else wide_bad++;
        if (pixel_x != 10'd0 || pixel_y != 10'(V_ACT)) coin_bad++;
      end
      if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
      prev_h = hsync; prev_v = vsync; prev_f = frame_clk;
    end
    total++;
    if (h_per_n == 0 || h_per_bad != 0) begin
      bad++;
      $display("FAIL hsync_period: samples=%0d wrong=%0d, required period %0d", h_per_n, h_per_bad, LINE_CLKS);
    end
    total++;
    if (h_low_n == 0 || h_low_bad != 0) begin
      bad++;
      $display("FAIL hsync_low: samples=%0d wrong=%0d, required %0d clk", h_low_n, h_low_bad, H_SYN * PDIV);
    end
    total++;
    if (v_per_n != 2 || v_per_bad != 0) begin
      bad++;
      $display("FAIL vsync_period: samples=%0d wrong=%0d, required 2 samples of %0d", v_per_n, v_per_bad, FRAME_CLKS);
    end
    total++;
    if (v_low_n != 3 || v_low_bad != 0) begin
      bad++;
      $display("FAIL vsync_low: samples=%0d wrong=%0d, required 3 of %0d clk", v_low_n, v_low_bad, V_SYN * LINE_CLKS);
    end
    total++;
    if (max_x != H_TOT - 1) begin
      bad++;
      $display("FAIL pixel_x_max: got %0d required %0d", max_x, H_TOT - 1);
    end
    total++;
    if (pulses != 3 || wide_bad != 0 || coin_bad != 0) begin
      bad++;
      $display("FAIL frame_clk: pulses=%0d wide=%0d off_position=%0d, required 3 0 0", pulses, wide_bad, coin_bad);
    end
  endtask

  task automatic test_ball;
    logic [7:0] v;
    logic ok;
    sample_pixel(100, 20, v, ok);
    total++;
    if (!ok || v !== 8'hFF) begin bad++; $display("FAIL ball_first: rgb=%h required ff", v); end
    sample_pixel(108, 20, v, ok);
    total++;
    if (!ok || v !== 8'h00) begin bad++; $display("FAIL ball_right_edge: rgb=%h required 00", v); end
    sample_pixel(107, 27, v, ok);
    total++;
    if (!ok || v !== 8'hFF) begin bad++; $display("FAIL ball_last: rgb=%h required ff", v); end
    sample_pixel(100, 28, v, ok);
    total++;
    if (!ok || v !== 8'h00) begin bad++; $display("FAIL ball_bottom_edge: rgb=%h required 00", v); end
  endtask

  task automatic test_no_tear;
    logic [7:0] v;
    logic ok;
    wait_line(10, ok);
    ball_pos_x = 10'd60;
    sample_pixel(60, 20, v, ok);
    total++;
    if (!ok || v !== 8'h00) begin bad++; $display("FAIL tear_new_early: rgb=%h required 00", v); end
    sample_pixel(100, 20, v, ok);
    total++;
    if (!ok || v !== 8'hFF) begin bad++; $display("FAIL tear_old_held: rgb=%h required ff", v); end
    sample_pixel(60, 20, v, ok);
    total++;
    if (!ok || v !== 8'hFF) begin bad++; $display("FAIL tear_new_next: rgb=%h required ff", v); end
    sample_pixel(100, 20, v, ok);
    total++;
    if (!ok || v !== 8'h00) begin bad++; $display("FAIL tear_old_gone: rgb=%h required 00", v); end
  endtask

  task automatic test_overlap_score;
    logic [7:0] row [0:H_ACT-1];
    logic [7:0] v, exp;
    logic ok;
    int prev, mism, nstart;
    int starts [0:3];
    ball_pos_x = 10'd14;  ball_pos_y = 10'd22;  ball_size = 10'd4;
    score_left = 4'd3;  score_right = 4'd2;  game_over_signal = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 2 * FRAME_CLKS; n++) begin
      @(negedge clk);
      if (frame_clk) begin ok = 1'b1; break; end
    end
    for (int x = 0; x < H_ACT; x++) row[x] = 8'hxx;
    if (ok) begin
      ok = 1'b0;
      for (int n = 0; n < 2 * FRAME_CLKS; n++) begin
        @(negedge clk);
        if (pixel_y == 10'd5 && pixel_x == 10'd0) begin ok = 1'b1; break; end
      end
    end
    prev = 0;
    if (ok) begin
      for (int n = 0; n < (H_ACT + 2) * PDIV; n++) begin
        @(negedge clk);
        if (int'(pixel_x) != prev) begin
          row[prev] = rgb;
          prev = int'(pixel_x);
          if (prev >= H_ACT) break;
        end
      end
    end
    mism = 0; nstart = 0;
    for (int x = 0; x < H_ACT; x++) begin
      exp = ((x >= 16 && x <= 23) || (x >= 28 && x <= 35) || (x >= 40 && x <= 47)) ? 8'hE0 : 8'h40;
      if (row[x] !== exp) mism++;
      if (row[x] === 8'hE0 && (x == 0 || row[x-1] !== 8'hE0)) begin
        if (nstart < 4) starts[nstart] = x;
        nstart++;
      end
    end
    total++;
    if (!ok || mism != 0) begin
      bad++;
      $display("FAIL score_row5: sync=%b wrong_pixels=%0d, required 0", ok, mism);
    end
    total++;
    if (nstart != 3 || starts[0] != 16 || starts[1] != 28 || starts[2] != 40) begin
      bad++;
      $display("FAIL score_blocks: count=%0d first=%0d, required 3 blocks at 16,28,40", nstart, starts[0]);
    end
    sample_pixel(15, 23, v, ok);
    total++;
    if (!ok || v !== 8'hFF) begin bad++; $display("FAIL ball_over_paddle: rgb=%h required ff", v); end
    sample_pixel(14, 28, v, ok);
    total++;
    if (!ok || v !== 8'h1C) begin bad++; $display("FAIL paddle_left: rgb=%h required 1c", v); end
    sample_pixel(18, 28, v, ok);
    total++;
    if (!ok || v !== 8'h40) begin bad++; $display("FAIL paddle_right_edge: rgb=%h required 40", v); end
    sample_pixel(17, 29, v, ok);
    total++;
    if (!ok || v !== 8'h1C) begin bad++; $display("FAIL paddle_last: rgb=%h required 1c", v); end
    sample_pixel(3, 30, v, ok);
    total++;
    if (!ok || v !== 8'h40) begin bad++; $display("FAIL border_outside: rgb=%h required 40", v); end
    sample_pixel(4, 30, v, ok);
    total++;
    if (!ok || v !== 8'h92) begin bad++; $display("FAIL border_bottom: rgb=%h required 92", v); end
  endtask

  task automatic test_reset_mid_frame;
    logic ok;
    int n;
    wait_line(25, ok);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (!ok || hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 8'h00 ||
        pixel_x !== 10'd0 || pixel_y !== 10'd0 || frame_clk !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: hs=%b vs=%b rgb=%h x=%0d y=%0d fclk=%b, required 1 1 00 0 0 0",
               hsync, vsync, rgb, pixel_x, pixel_y, frame_clk);
    end
    ok = 1'b0;
    for (n = 1; n <= 2 * FRAME_CLKS; n++) begin
      @(negedge clk);
      if (frame_clk) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || n != V_ACT * LINE_CLKS + PDIV - 1) begin
      bad++;
      $display("FAIL reset_first_frame: pulse after %0d clk, required %0d", n, V_ACT * LINE_CLKS + PDIV - 1);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_ball();
    test_no_tear();
    test_overlap_score();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
